// File: rtl/quant_pkg.sv
// Shared widths, int8 saturation bounds and dequant FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package quant_pkg;

    localparam int ACT_W = 8;
    localparam int ZP_W  = 8;
    localparam int DEQ_W = 9;

    localparam logic signed [DEQ_W-1:0] INT8_MIN = -9'sd128;
    localparam logic signed [DEQ_W-1:0] INT8_MAX = 9'sd127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dq_state_t;

endpackage

// File: rtl/dequant_lane.sv
// One lane: q - zero_point as 9-bit signed; DEQUANT_CLAMP_INT8_EN saturates to int8 range.
// Latency: combinational.
// Backpressure: none, pure function of inputs.
module dequant_lane
    import quant_pkg::*;
(
    input  logic        [ACT_W-1:0] q,
    input  logic        [ZP_W-1:0]  zp,
    output logic signed [DEQ_W-1:0] d
);

    logic signed [DEQ_W-1:0] diff;

    // Both operands zero-extended, so the 9-bit difference spans [-255,255] exactly.
    assign diff = $signed({1'b0, q}) - $signed({1'b0, zp});

`ifdef DEQUANT_CLAMP_INT8_EN
    always_comb begin
        d = diff;
        if (diff > INT8_MAX) begin
            d = INT8_MAX;
        end else if (diff < INT8_MIN) begin
            d = INT8_MIN;
        end
    end
`else
    assign d = diff;
`endif

endmodule

// File: rtl/module_dequant_stream.sv
// Streams uint8 beats to signed 9-bit lanes with optional zero border (DEQUANT_CLAMP_INT8_EN clamps).
// Latency: one cycle from accepted input beat (or border slot) to m_valid.
// Backpressure: m_valid && !m_ready holds m_data, freezes counters and drops s_ready.
module module_dequant_stream
    import quant_pkg::*;
#(
    parameter int LANES = 8,
    parameter int DIM_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIM_W-1:0]       cfg_width,
    input  logic [DIM_W-1:0]       cfg_height,
    input  logic                   cfg_pad,
    input  logic [7:0]             zero_point,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*8-1:0]     s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*9-1:0]     m_data,
    output logic                   busy,
    output logic                   done
);

    // One extra bit: padded frame dimension can reach 1025.
    localparam int CW = DIM_W + 1;

    dq_state_t              state_q, state_d;
    logic [DIM_W-1:0]       width_q, height_q;
    logic                   pad_q;
    logic [ZP_W-1:0]        zp_q;
    logic [CW-1:0]          col_q, row_q;
    logic [CW-1:0]          col_last, row_last, pad2;
    logic                   col_int, row_int, interior;
    logic                   load_en, advance, last_beat, run;
    logic [LANES*DEQ_W-1:0] lane_dat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dequant_lane u_lane (
            .q  (s_data[i*ACT_W +: ACT_W]),
            .zp (zp_q),
            .d  (lane_dat[i*DEQ_W +: DEQ_W])
        );
    end

    assign pad2      = {{(CW-2){1'b0}}, pad_q, 1'b0};
    assign col_last  = {1'b0, width_q}  + pad2 - CW'(1);
    assign row_last  = {1'b0, height_q} + pad2 - CW'(1);
    assign col_int   = !pad_q || ((col_q != '0) && (col_q != col_last));
    assign row_int   = !pad_q || ((row_q != '0) && (row_q != row_last));
    assign interior  = col_int && row_int;
    assign last_beat = (col_q == col_last) && (row_q == row_last);
    assign run       = (state_q == RUN);
    assign load_en   = !m_valid || m_ready;
    // Border slots need no input; interior slots wait for s_valid.
    assign advance   = run && load_en && (!interior || s_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (advance && last_beat) state_d = DRAIN;
            DRAIN:   if (m_valid && m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        s_ready = 1'b0;
        if (state_q != IDLE) busy = 1'b1;
        if (run && interior && load_en) s_ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width_q  <= '0;
            height_q <= '0;
            pad_q    <= 1'b0;
            zp_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state_q == IDLE) && start) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                pad_q    <= cfg_pad;
                zp_q     <= zero_point;
                col_q    <= '0;
                row_q    <= '0;
            end
            if (advance) begin
                m_valid <= 1'b1;
                m_data  <= interior ? lane_dat : '0;
                if (col_q == col_last) begin
                    col_q <= '0;
                    row_q <= row_q + CW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if ((state_q == DRAIN) && m_valid && m_ready) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_dequant_stream.sv
// Scoreboard bench: frame model pushes expected beats, a monitor pops them on each output handshake.
`timescale 1ns/1ps
module tb_module_dequant_stream;

    localparam int LANES = 8;
    localparam int DIM_W = 10;

    typedef logic [LANES*8-1:0] in_t;
    typedef logic [LANES*9-1:0] out_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] cfg_width = '0;
    logic [DIM_W-1:0] cfg_height = '0;
    logic             cfg_pad = 1'b0;
    logic [7:0]       zero_point = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    in_t              s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    out_t             m_data;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    module_dequant_stream #(.LANES(LANES), .DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_pad    (cfg_pad),
        .zero_point (zero_point),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done)
    );

    in_t  frame_in[$];
    in_t  in_q[$];
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   in_cnt = 0;
    int   first_acc_cyc = 0;
    int   last_acc_cyc = 0;
    bit   rand_ready = 1'b0;
    bit   gaps = 1'b0;
    bit   prev_stall = 1'b0;
    bit   s_hs = 1'b0;
    out_t held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: integer subtraction, saturated only in the clamped build.
    function automatic logic [8:0] deq(input int q, input int zp);
        int d;
        d = q - zp;
`ifdef DEQUANT_CLAMP_INT8_EN
        if (d > 127) d = 127;
        if (d < -128) d = -128;
`endif
        return 9'(d);
    endfunction

    function automatic out_t expect_beat(input in_t b, input int zp);
        out_t r;
        for (int i = 0; i < LANES; i++) r[i*9 +: 9] = deq(int'(b[i*8 +: 8]), zp);
        return r;
    endfunction

    task automatic rand_frame(input int n);
        frame_in.delete();
        for (int i = 0; i < n; i++) frame_in.push_back(in_t'({$urandom(), $urandom()}));
    endtask

    // Monitor and source driver: sample at negedge, drive #1 after posedge.
    initial begin
        forever begin
            @(negedge clk);
            s_hs = rst_n && s_valid && s_ready;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("stall_hold", {m_valid, m_data}, {1'b1, held});
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_beat: got %h expected no beat", m_data);
                    end else begin
                        check("beat", m_data, exp_q.pop_front());
                    end
                    if (acc_cnt == 0) first_acc_cyc = cyc;
                    last_acc_cyc = cyc;
                    acc_cnt++;
                end
                if (s_hs) in_cnt++;
                prev_stall = m_valid && !m_ready;
                held = m_data;
            end
            @(posedge clk);
            #1;
            if (s_hs && in_q.size() > 0) void'(in_q.pop_front());
            s_valid = (in_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
            s_data  = (in_q.size() > 0) ? in_q[0] : '0;
            m_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    task automatic launch_frame(input int w, input int h, input int p, input int zp, input bit restart);
        int k;
        k = 0;
        acc_cnt = 0;
        in_cnt = 0;
        for (int r = 0; r < h + 2*p; r++) begin
            for (int c = 0; c < w + 2*p; c++) begin
                if (c >= p && c < p + w && r >= p && r < p + h) begin
                    exp_q.push_back(expect_beat(frame_in[k], zp));
                    k++;
                end else begin
                    exp_q.push_back('0);
                end
            end
        end
        in_q = frame_in;
        @(posedge clk); #1;
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_pad = 1'(p);
        zero_point = 8'(zp); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config mid-frame; the latched values must govern the frame.
        cfg_width = DIM_W'($urandom_range(1, 5));
        cfg_height = DIM_W'($urandom_range(1, 5));
        cfg_pad = 1'($urandom_range(1));
        zero_point = 8'($urandom);
        if (restart) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic finish_frame(input int w, input int h);
        int t;
        t = 0;
        @(negedge clk);
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 5000 cycles");
        end else begin
            check("done_timing", cyc, last_acc_cyc + 1);
            check("busy_at_done", busy, 0);
        end
        check("inputs_consumed", in_cnt, w * h);
        check("exp_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        in_t b;
        int  t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_data", m_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Back-to-back 2x2, zp=128.
        frame_in.delete();
        foreach (frame_in[i]) ;
        for (int i = 0; i < 4; i++) begin
            b = in_t'({$urandom(), $urandom()});
            case (i)
                0: b[7:0] = 8'd128;
                1: b[7:0] = 8'd255;
                2: b[7:0] = 8'd0;
                default: b[7:0] = 8'd130;
            endcase
            frame_in.push_back(b);
        end
        launch_frame(2, 2, 0, 128, 1'b0);
        finish_frame(2, 2);
        check("throughput", last_acc_cyc - first_acc_cyc, 3);

        // Padded 2x1, zp=10.
        frame_in.delete();
        b = in_t'({$urandom(), $urandom()}); b[7:0] = 8'd10; frame_in.push_back(b);
        b = in_t'({$urandom(), $urandom()}); b[7:0] = 8'd20; frame_in.push_back(b);
        launch_frame(2, 1, 1, 10, 1'b0);
        finish_frame(2, 1);
        check("pad_beats", acc_cnt, 12);

        // Range extremes on single-beat frames.
        frame_in.delete(); frame_in.push_back({LANES{8'hFF}});
        launch_frame(1, 1, 0, 0, 1'b0);
        finish_frame(1, 1);
        frame_in.delete(); frame_in.push_back('0);
        launch_frame(1, 1, 0, 255, 1'b0);
        finish_frame(1, 1);

        // Stalls, source gaps and an ignored start during RUN.
        rand_ready = 1'b1;
        gaps = 1'b1;
        rand_frame(9);
        launch_frame(3, 3, 1, int'($urandom_range(255)), 1'b1);
        finish_frame(3, 3);
        for (int n = 0; n < 3; n++) begin
            int w, h, p;
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 3);
            p = $urandom_range(1);
            rand_frame(w * h);
            launch_frame(w, h, p, int'($urandom_range(255)), 1'b0);
            finish_frame(w, h);
        end

        // Reset mid-frame, then a clean frame.
        rand_ready = 1'b0;
        gaps = 1'b0;
        rand_frame(9);
        launch_frame(3, 3, 1, 77, 1'b0);
        t = 0;
        while (acc_cnt < 3 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached_beat3", acc_cnt >= 3, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        in_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        rand_frame(9);
        launch_frame(3, 3, 1, 200, 1'b0);
        finish_frame(3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule
